// File: rtl/axi_wr_arbiter_pkg.sv
//------------------------------------------------------------------------------
// axi_wr_arbiter_pkg : AXI4 write-channel types and write-arbiter state type
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi_wr_arbiter_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ID_W-1:0]   axi_id_t;
    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_STRB_W-1:0] axi_strb_t;
    typedef logic [3:0]            axi_len_t;
    typedef logic [1:0]            axi_burst_t;
    typedef logic [1:0]            axi_resp_t;

    localparam axi_burst_t BURST_FIXED = 2'b00;
    localparam axi_burst_t BURST_INCR  = 2'b01;
    localparam axi_burst_t BURST_WRAP  = 2'b10;

    localparam axi_resp_t OKAY   = 2'b00;
    localparam axi_resp_t EXOKAY = 2'b01;
    localparam axi_resp_t SLVERR = 2'b10;
    localparam axi_resp_t DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } axi_wr_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_wr_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// axi_rr_pick : combinational round-robin picker, lowest index at/after ptr
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_o
);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest requester overrides.
    always_comb begin
        winner_o = '0;
        w_idx    = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            w_idx = IDX_W'((int'(rr_ptr_i) + i) % NUM_M);
            if (req_i[w_idx]) begin
                winner_o = w_idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
//------------------------------------------------------------------------------
// axi_wr_arbiter : round-robin sharing of one AXI4 write slave among NUM_M masters
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       s_awvalid [NUM_M],
    output logic       s_awready [NUM_M],
    input  axi_id_t    s_awid    [NUM_M],
    input  axi_addr_t  s_awaddr  [NUM_M],
    input  axi_len_t   s_awlen   [NUM_M],
    input  logic [2:0] s_awsize  [NUM_M],
    input  axi_burst_t s_awburst [NUM_M],
    input  logic       s_wvalid  [NUM_M],
    output logic       s_wready  [NUM_M],
    input  logic       s_wlast   [NUM_M],
    input  axi_data_t  s_wdata   [NUM_M],
    input  axi_strb_t  s_wstrb   [NUM_M],
    output logic       s_bvalid  [NUM_M],
    input  logic       s_bready  [NUM_M],
    output axi_id_t    s_bid,
    output axi_resp_t  s_bresp,
    output logic       m_awvalid,
    input  logic       m_awready,
    output axi_id_t    m_awid,
    output axi_addr_t  m_awaddr,
    output axi_len_t   m_awlen,
    output logic [2:0] m_awsize,
    output axi_burst_t m_awburst,
    output logic       m_wvalid,
    input  logic       m_wready,
    output logic       m_wlast,
    output axi_data_t  m_wdata,
    output axi_strb_t  m_wstrb,
    input  logic       m_bvalid,
    output logic       m_bready,
    input  axi_id_t    m_bid,
    input  axi_resp_t  m_bresp,
    output logic [IDX_W-1:0] grant_o,
    output logic       busy_o,
    output logic       err_wlast_o,
    output logic       err_resp_o
);

    axi_wr_arb_state_t state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    axi_len_t          beats_q, beats_d;
    logic              busy_q;
    logic              err_wlast_q, err_wlast_d;
    logic              err_resp_q, err_resp_d;

    logic [NUM_M-1:0]  w_req;
    logic [IDX_W-1:0]  w_winner;
    logic              w_any;
    logic              w_last_beat;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_M; i++) begin
            w_req[i] = s_awvalid[i];
        end
    end

    axi_rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (w_req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    assign w_last_beat = (beats_q == '0);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beats_q     <= '0;
            busy_q      <= 1'b0;
            err_wlast_q <= 1'b0;
            err_resp_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beats_q     <= beats_d;
            busy_q      <= (state_d != IDLE);
            err_wlast_q <= err_wlast_d;
            err_resp_q  <= err_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beats_d     = beats_q;
        err_wlast_d = 1'b0;
        err_resp_d  = 1'b0;

        for (int i = 0; i < NUM_M; i++) begin
            s_awready[i] = 1'b0;
            s_wready[i]  = 1'b0;
            s_bvalid[i]  = 1'b0;
        end
        s_bid     = m_bid;
        s_bresp   = m_bresp;
        m_awvalid = 1'b0;
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    grant_d = w_winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_awvalid          = s_awvalid[grant_q];
                m_awid             = s_awid[grant_q];
                m_awaddr           = s_awaddr[grant_q];
                m_awlen            = s_awlen[grant_q];
                m_awsize           = s_awsize[grant_q];
                m_awburst          = s_awburst[grant_q];
                s_awready[grant_q] = m_awready;
                if (s_awvalid[grant_q] && m_awready) begin
                    beats_d = s_awlen[grant_q];
                    state_d = DATA;
                end
            end
            DATA: begin
                // Burst length comes from AWLEN alone; the master's WLAST is only audited.
                m_wvalid          = s_wvalid[grant_q];
                m_wdata           = s_wdata[grant_q];
                m_wstrb           = s_wstrb[grant_q];
                m_wlast           = w_last_beat;
                s_wready[grant_q] = m_wready;
                if (s_wvalid[grant_q] && m_wready) begin
                    err_wlast_d = (s_wlast[grant_q] != w_last_beat);
                    if (w_last_beat) begin
                        state_d = RESP;
                    end else begin
                        beats_d = beats_q - axi_len_t'(1);
                    end
                end
            end
            RESP: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = s_bready[grant_q];
                if (m_bvalid && s_bready[grant_q]) begin
                    err_resp_d = (m_bresp != OKAY);
                    rr_ptr_d   = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign err_wlast_o = err_wlast_q;
    assign err_resp_o  = err_resp_q;

endmodule

`default_nettype wire
